// File: rtl/razor_err_ctrl.sv
// rtl/razor_err_ctrl.sv - Razor error-recovery and voltage/frequency tuning controller
// Optional per-stage sticky error flags are built only when RAZOR_ERR_STICKY_EN is defined.
module razor_err_ctrl #(
    parameter int NSTAGE = 4,
    parameter int WINDOW = 1024,
    parameter int CNT_W  = 8,
    parameter int HI_THR = 16,
    parameter int LO_THR = 0,
    parameter int HOLD   = 2,
    localparam int RS_W  = (NSTAGE > 1) ? $clog2(NSTAGE) : 1
) (
    input  logic              Clock_Sys,
    input  logic              Reset,
    input  logic              Enable,
    input  logic [NSTAGE-1:0] ErrorIn,
    output logic              GlobalError,
    output logic              Replay_Valid,
    output logic [RS_W-1:0]   Replay_Stage,
    output logic [CNT_W-1:0]  ErrCount,
    output logic              Tune_Req,
    output logic              Tune_Up,
`ifdef RAZOR_ERR_STICKY_EN
    output logic [NSTAGE-1:0] Sticky,
    input  logic              Sticky_Clr,
`endif
    input  logic              Tune_Ack
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_RECOVER = 2'd2;

    localparam int WIN_W  = $clog2(WINDOW);
    localparam int HOLD_W = $clog2(HOLD + 1);

    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD);
    localparam logic [CNT_W-1:0]  HI_T      = CNT_W'(HI_THR);
    localparam logic [CNT_W-1:0]  LO_T      = CNT_W'(LO_THR);

    logic [1:0]        state;
    logic [HOLD_W-1:0] rec_cnt;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic [RS_W-1:0]   low_idx;
    logic              any_err;
    logic              active;
    logic              can_trig;
    logic              trigger;
    logic              win_term;
    logic              dec_hi;
    logic              dec_lo;

    always_comb begin
        low_idx = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (ErrorIn[i]) low_idx = RS_W'(i);
        end
    end

    // The last hold-off cycle may fire again, so a persistent error pulses every HOLD+1 cycles.
    assign any_err  = |ErrorIn;
    assign active   = (state != S_IDLE);
    assign can_trig = (state == S_RUN) || ((state == S_RECOVER) && (rec_cnt == HOLD_LAST));
    assign trigger  = Enable && can_trig && any_err;
    assign win_term = (win_cnt == WIN_LAST);
    assign cnt_next = (any_err && (err_cnt != {CNT_W{1'b1}})) ? err_cnt + CNT_W'(1) : err_cnt;
    assign dec_hi   = (cnt_next >= HI_T);
    assign dec_lo   = (cnt_next <= LO_T);

    always_ff @(posedge Clock_Sys) begin
        if (Reset) begin
            state        <= S_IDLE;
            rec_cnt      <= '0;
            win_cnt      <= '0;
            err_cnt      <= '0;
            GlobalError  <= 1'b0;
            Replay_Valid <= 1'b0;
            Replay_Stage <= '0;
            ErrCount     <= '0;
            Tune_Req     <= 1'b0;
            Tune_Up      <= 1'b0;
        end else begin
            GlobalError  <= trigger;
            Replay_Valid <= trigger;
            if (trigger) Replay_Stage <= low_idx;

            case (state)
                S_IDLE: begin
                    if (Enable) state <= S_RUN;
                end
                S_RUN: begin
                    if (!Enable) begin
                        state <= S_IDLE;
                    end else if (any_err) begin
                        state   <= S_RECOVER;
                        rec_cnt <= '0;
                    end
                end
                S_RECOVER: begin
                    if (!Enable) begin
                        state <= S_IDLE;
                    end else if (rec_cnt == HOLD_LAST) begin
                        if (any_err) rec_cnt <= '0;
                        else         state   <= S_RUN;
                    end else begin
                        rec_cnt <= rec_cnt + HOLD_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (Tune_Req && Tune_Ack) Tune_Req <= 1'b0;

            // A decision landing while a request is outstanding is dropped, not queued.
            if (active && win_term) begin
                ErrCount <= cnt_next;
                if (!Tune_Req && (dec_hi || dec_lo)) begin
                    Tune_Req <= 1'b1;
                    Tune_Up  <= dec_hi;
                end
            end

            if (!active || !Enable || win_term) begin
                win_cnt <= '0;
                err_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                err_cnt <= cnt_next;
            end
        end
    end

`ifdef RAZOR_ERR_STICKY_EN
    always_ff @(posedge Clock_Sys) begin
        if (Reset) Sticky <= '0;
        else       Sticky <= (Sticky & ~{NSTAGE{Sticky_Clr}}) | ErrorIn;
    end
`endif

endmodule
